mii_rx_deframer: RTL and testbench
==================================

MII_RX_DEFRAMER -- requirements
Module: mii_rx_deframer

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64: minimum legal frame length in bytes, FCS included.
REQ-002 SHALL have parameter MAX_LEN, default 1518: maximum legal frame length in bytes, FCS included.
REQ-003 SHALL have port rx_clki, input, 1 bit: PHY receive clock; the only clock in the block.
REQ-004 SHALL have port rx_rst_n, input, 1 bit: reset; synchronous to rx_clki, active-low.
REQ-005 SHALL have port phy_rx_dv, input, 1 bit: MII receive data valid.
REQ-006 SHALL have ports phy_rxd0..phy_rxd3, input, 1 bit each: MII receive nibble; rxd0 is the LSB.
REQ-007 SHALL have port rx_data, output, 8 bits: received byte.
REQ-008 SHALL have port rx_valid, output, 1 bit: rx_data is valid this cycle.
REQ-009 SHALL have port rx_sof, output, 1 bit: asserts with the first byte after the SFD.
REQ-010 SHALL have port rx_eof, output, 1 bit: one-cycle pulse marking frame end; status outputs valid.
REQ-011 SHALL have port rx_len, output, 11 bits: byte count of the last frame.
REQ-012 SHALL have port rx_crc_ok, output, 1 bit: FCS check passed for the last frame.
REQ-013 SHALL have port rx_err, output, 4 bits: {odd_nibble, too_long, runt, crc_bad} for the last frame.
REQ-014 SHALL have ports frame_ok_cnt and frame_bad_cnt, output, 16 bits each: saturating frame counters.

Function
REQ-015 SHALL implement four states: IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: dv=1 with nibble 0x5 -> PREAMBLE; dv=1 with any other nibble -> DROP.
REQ-017 PREAMBLE: nibble 0x5 -> stay; nibble 0xD -> DATA (SFD); any other nibble -> DROP; dv=0 -> IDLE; no rx_eof and no counter change in any of these cases.
REQ-018 DROP: hold until dv=0, then go to IDLE; no output activity.
REQ-019 DATA byte assembly: the first sampled nibble is the low nibble and the second is the high nibble; rx_valid=1 and rx_data={high,low} in the cycle after the edge that samples the high nibble.
REQ-020 rx_sof SHALL be 1 only with the first rx_valid of a frame.
REQ-021 FCS bytes SHALL be passed on rx_data and counted in rx_len.
REQ-022 CRC: Ethernet CRC-32 (reflected, poly 0xEDB88320, init 0xFFFFFFFF), updated per byte over all bytes including the FCS.
REQ-023 crc_ok SHALL be 1 when the final CRC register equals 0xDEBB20E3.
REQ-024 Byte counter SHALL be 11 bits; once it reaches MAX_LEN, further bytes SHALL not be emitted and too_long SHALL be set; rx_len then reports MAX_LEN+1.
REQ-025 End of frame: on the edge sampling dv=0 in DATA, in the following cycle assert rx_eof for one cycle, update rx_len, rx_crc_ok and rx_err, and return to IDLE.
REQ-026 rx_len, rx_crc_ok and rx_err SHALL hold until the next rx_eof.
REQ-027 odd_nibble SHALL be set if dv falls after a low nibble; the partial byte SHALL be discarded.
REQ-028 runt SHALL be set if byte count < MIN_LEN.
REQ-029 crc_bad SHALL equal ~crc_ok.
REQ-030 At rx_eof, frame_ok_cnt SHALL increment if rx_err==0, else frame_bad_cnt SHALL increment; both counters saturate at 0xFFFF.
REQ-031 rx_valid and rx_eof SHALL never be asserted in the same cycle.
REQ-032 No backpressure: the consumer SHALL accept every rx_valid byte.

Reset
REQ-033 While rx_rst_n=0 at a rising edge: state=DROP; rx_data=0, rx_valid=0, rx_sof=0, rx_eof=0, rx_len=0, rx_crc_ok=0, rx_err=0, both counters=0, CRC register=0xFFFFFFFF.
REQ-034 After reset release: if dv is still 1 (reset mid-frame), remain in DROP until dv=0; no rx_eof for the aborted frame.

Verification
REQ-035 Bench: 60 bytes 0x00..0x3B + correct FCS (64 bytes total), 7x 0x55 preamble + 0xD5 SFD -> 64 rx_valid pulses, rx_sof on byte 0x00, rx_eof with rx_len=64, rx_crc_ok=1, rx_err=0, frame_ok_cnt=1.
REQ-036 Bench: payload "123456789" + FCS 26 39 F4 CB -> rx_len=13, rx_crc_ok=1, rx_err=4'b0010 (runt), frame_bad_cnt=1.
REQ-037 Bench: 64-byte frame with one payload bit flipped -> rx_err=4'b0001, rx_crc_ok=0.
REQ-038 Bench: 1600-byte frame -> exactly 1518 rx_valid pulses, rx_len=1519, too_long set.
REQ-039 Bench: frame ending with an extra low nibble -> odd_nibble set, rx_len excludes the partial byte; then first preamble nibble 0x7 -> DROP, no rx_eof.
REQ-040 Bench: rx_rst_n pulsed low for 1 cycle mid-frame with dv held high -> all outputs 0, no rx_valid/rx_eof until dv low; the next good frame is received normally.

Source files
------------

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, assembles nibbles into bytes,
// checks Ethernet FCS and frame length, and keeps saturating frame counters.
module mii_rx_deframer #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic        rx_clki,
    input  logic        rx_rst_n,
    input  logic        phy_rx_dv,
    input  logic        phy_rxd0,
    input  logic        phy_rxd1,
    input  logic        phy_rxd2,
    input  logic        phy_rxd3,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic [10:0] rx_len,
    output logic        rx_crc_ok,
    output logic [3:0]  rx_err,
    output logic [15:0] frame_ok_cnt,
    output logic [15:0] frame_bad_cnt
);
    localparam int unsigned LEN_W = 11;
    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [3:0]  NIB_PRE     = 4'h5;
    localparam logic [3:0]  NIB_SFD     = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_DATA     = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [3:0]         w_nib;
    logic [7:0]         w_byte;
    logic               w_sfd;
    logic               w_low_done;
    logic               w_byte_done;
    logic               w_frame_end;
    logic [31:0]        w_crc_nxt;
    logic               w_crc_ok;
    logic               w_too_long;
    logic               w_runt;
    logic [3:0]         w_err;

    logic               r_half;
    logic [3:0]         r_low;
    logic [31:0]        r_crc;
    logic [LEN_W-1:0]   r_cnt;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_rx_sof;
    logic               r_rx_eof;
    logic [LEN_W-1:0]   r_rx_len;
    logic               r_rx_crc_ok;
    logic [3:0]         r_rx_err;
    logic [CNT_W-1:0]   r_ok_cnt;
    logic [CNT_W-1:0]   r_bad_cnt;

    // Reflected CRC-32, one byte per call
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        w_nib       = {phy_rxd3, phy_rxd2, phy_rxd1, phy_rxd0};
        w_byte      = {w_nib, r_low};
        w_sfd       = (r_state == S_PREAMBLE) && phy_rx_dv && (w_nib == NIB_SFD);
        w_low_done  = (r_state == S_DATA) && phy_rx_dv && !r_half;
        w_byte_done = (r_state == S_DATA) && phy_rx_dv && r_half;
        w_frame_end = (r_state == S_DATA) && !phy_rx_dv;
        w_crc_nxt   = crc_byte(r_crc, w_byte);
        w_crc_ok    = (r_crc == CRC_RESIDUE);
        w_too_long  = (r_cnt > LEN_W'(MAX_LEN));
        w_runt      = (r_cnt < LEN_W'(MIN_LEN));
        // A pending low nibble at dv fall marks a truncated byte
        w_err       = {r_half, w_too_long, w_runt, ~w_crc_ok};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (phy_rx_dv) begin
                    w_state_nxt = (w_nib == NIB_PRE) ? S_PREAMBLE : S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!phy_rx_dv) begin
                    w_state_nxt = S_IDLE;
                end else if (w_nib == NIB_SFD) begin
                    w_state_nxt = S_DATA;
                end else if (w_nib != NIB_PRE) begin
                    w_state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                if (!phy_rx_dv) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                if (!phy_rx_dv) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_DROP;
        endcase
    end

    // Reset lands in DROP so a frame interrupted by reset is ignored until dv falls
    always_ff @(posedge rx_clki) begin
        if (!rx_rst_n) begin
            r_state <= S_DROP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge rx_clki) begin
        if (!rx_rst_n) begin
            r_half      <= 1'b0;
            r_low       <= '0;
            r_crc       <= CRC_INIT;
            r_cnt       <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_sof    <= 1'b0;
            r_rx_eof    <= 1'b0;
            r_rx_len    <= '0;
            r_rx_crc_ok <= 1'b0;
            r_rx_err    <= '0;
            r_ok_cnt    <= '0;
            r_bad_cnt   <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_sof   <= 1'b0;
            r_rx_eof   <= 1'b0;
            if (w_sfd) begin
                r_crc  <= CRC_INIT;
                r_cnt  <= '0;
                r_half <= 1'b0;
            end
            if (w_low_done) begin
                r_low  <= w_nib;
                r_half <= 1'b1;
            end
            if (w_byte_done) begin
                r_half <= 1'b0;
                // Past MAX_LEN the count parks at MAX_LEN+1 and bytes are swallowed
                if (r_cnt < LEN_W'(MAX_LEN)) begin
                    r_rx_data  <= w_byte;
                    r_rx_valid <= 1'b1;
                    r_rx_sof   <= (r_cnt == '0);
                    r_crc      <= w_crc_nxt;
                    r_cnt      <= r_cnt + LEN_W'(1);
                end else begin
                    r_cnt <= LEN_W'(MAX_LEN + 1);
                end
            end
            if (w_frame_end) begin
                r_half      <= 1'b0;
                r_rx_eof    <= 1'b1;
                r_rx_len    <= r_cnt;
                r_rx_crc_ok <= w_crc_ok;
                r_rx_err    <= w_err;
                if (w_err == '0) begin
                    if (r_ok_cnt != '1) r_ok_cnt <= r_ok_cnt + CNT_W'(1);
                end else begin
                    if (r_bad_cnt != '1) r_bad_cnt <= r_bad_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_sof        = r_rx_sof;
    assign rx_eof        = r_rx_eof;
    assign rx_len        = r_rx_len;
    assign rx_crc_ok     = r_rx_crc_ok;
    assign rx_err        = r_rx_err;
    assign frame_ok_cnt  = r_ok_cnt;
    assign frame_bad_cnt = r_bad_cnt;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Self-checking bench for mii_rx_deframer: directed frames plus randomized frames
// compared against a frame-level model (FCS = CRC-32 of the preceding bytes).
module tb_mii_rx_deframer;
    localparam int unsigned MIN_LEN = 64;
    localparam int unsigned MAX_LEN = 1518;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        dv;
    logic [3:0]  nib;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic [10:0] rx_len;
    logic        rx_crc_ok;
    logic [3:0]  rx_err;
    logic [15:0] ok_cnt;
    logic [15:0] bad_cnt;

    mii_rx_deframer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .rx_clki      (clk),
        .rx_rst_n     (rst_n),
        .phy_rx_dv    (dv),
        .phy_rxd0     (nib[0]),
        .phy_rxd1     (nib[1]),
        .phy_rxd2     (nib[2]),
        .phy_rxd3     (nib[3]),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_sof       (rx_sof),
        .rx_eof       (rx_eof),
        .rx_len       (rx_len),
        .rx_crc_ok    (rx_crc_ok),
        .rx_err       (rx_err),
        .frame_ok_cnt (ok_cnt),
        .frame_bad_cnt(bad_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  tx_bytes[$];
    logic [7:0]  got_bytes[$];
    logic [7:0]  exp_bytes[$];
    int          sof_idx[$];
    int          n_eof;
    int          n_both;
    int          n_sof_stray;
    logic [10:0] eof_len;
    logic        eof_crc;
    logic [3:0]  eof_err;
    int unsigned exp_len;
    logic        exp_crc_ok;
    logic [3:0]  exp_err;
    int unsigned exp_ok  = 0;
    int unsigned exp_bad = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_sof) sof_idx.push_back(int'(got_bytes.size()));
            got_bytes.push_back(rx_data);
        end else if (rx_sof) begin
            n_sof_stray++;
        end
        if (rx_eof) begin
            n_eof++;
            eof_len = rx_len;
            eof_crc = rx_crc_ok;
            eof_err = rx_err;
        end
        if (rx_valid && rx_eof) n_both++;
    end

    function automatic logic [31:0] crc32_of(input int unsigned n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int unsigned i = 0; i < n; i++) begin
            c = c ^ {24'h0, tx_bytes[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic append_fcs();
        logic [31:0] c;
        c = crc32_of(tx_bytes.size());
        tx_bytes.push_back(c[7:0]);
        tx_bytes.push_back(c[15:8]);
        tx_bytes.push_back(c[23:16]);
        tx_bytes.push_back(c[31:24]);
    endtask

    // Frame-level expectations from the byte list and whether a stray nibble follows
    task automatic model(input logic odd);
        int unsigned n, emit;
        logic [31:0] c, fcs;
        logic        ok;
        n    = tx_bytes.size();
        emit = (n < MAX_LEN) ? n : MAX_LEN;
        exp_bytes.delete();
        for (int unsigned i = 0; i < emit; i++) exp_bytes.push_back(tx_bytes[i]);
        ok = 1'b0;
        if (emit >= 4) begin
            c   = crc32_of(emit - 4);
            fcs = {tx_bytes[emit-1], tx_bytes[emit-2], tx_bytes[emit-3], tx_bytes[emit-4]};
            ok  = (c == fcs);
        end
        exp_len    = (n > MAX_LEN) ? MAX_LEN + 1 : n;
        exp_crc_ok = ok;
        exp_err    = {odd, (n > MAX_LEN), (exp_len < MIN_LEN), !ok};
        if (exp_err == 4'd0) begin
            if (exp_ok < 65535) exp_ok++;
        end else begin
            if (exp_bad < 65535) exp_bad++;
        end
    endtask

    task automatic nib_cyc(input logic v, input logic [3:0] n);
        @(negedge clk);
        dv  = v;
        nib = n;
    endtask

    task automatic send_preamble(input int n5);
        repeat (n5) nib_cyc(1'b1, 4'h5);
        nib_cyc(1'b1, 4'hD);
    endtask

    task automatic send_bytes(input int from, input int to);
        logic [7:0] b;
        for (int i = from; i < to; i++) begin
            b = tx_bytes[i];
            nib_cyc(1'b1, b[3:0]);
            nib_cyc(1'b1, b[7:4]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) nib_cyc(1'b0, 4'($urandom));
    endtask

    task automatic clear_mon();
        got_bytes.delete();
        sof_idx.delete();
        n_eof       = 0;
        n_both      = 0;
        n_sof_stray = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dv    = 1'b0;
        nib   = 4'h0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({rx_data, rx_valid, rx_sof, rx_eof, rx_len, rx_crc_ok, rx_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%0h v=%0b s=%0b e=%0b len=%0d ok=%0b err=%0b expected all 0",
                     rx_data, rx_valid, rx_sof, rx_eof, rx_len, rx_crc_ok, rx_err);
        end
        n_tests++;
        if ({ok_cnt, bad_cnt} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got ok=%0d bad=%0d expected 0/0", ok_cnt, bad_cnt);
        end
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_good_frame();
        int bad_i;
        tx_bytes.delete();
        for (int i = 0; i < 60; i++) tx_bytes.push_back(8'(i));
        append_fcs();
        model(1'b0);
        clear_mon();
        send_preamble(15);
        send_bytes(0, tx_bytes.size());
        idle(4);
        n_tests++;
        if (got_bytes.size() !== 64) begin
            n_fail++;
            $display("FAIL good_valid_count: got %0d expected 64", got_bytes.size());
        end
        bad_i = -1;
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            if (bad_i < 0 && got_bytes[i] !== exp_bytes[i]) bad_i = i;
        n_tests++;
        if (bad_i >= 0) begin
            n_fail++;
            $display("FAIL good_data: byte %0d got %0h expected %0h", bad_i, got_bytes[bad_i], exp_bytes[bad_i]);
        end
        n_tests++;
        if (sof_idx.size() != 1 || sof_idx[0] != 0 || n_sof_stray != 0 || got_bytes[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL good_sof: got %0d sofs first at %0d stray %0d expected one on byte 0",
                     sof_idx.size(), sof_idx[0], n_sof_stray);
        end
        n_tests++;
        if (n_eof != 1 || eof_len !== 11'd64 || eof_crc !== 1'b1 || eof_err !== 4'b0000) begin
            n_fail++;
            $display("FAIL good_status: got eofs=%0d len=%0d crc_ok=%0b err=%b expected 1/64/1/0000",
                     n_eof, eof_len, eof_crc, eof_err);
        end
        n_tests++;
        if (ok_cnt !== 16'd1 || bad_cnt !== 16'd0 || n_both != 0) begin
            n_fail++;
            $display("FAIL good_counters: got ok=%0d bad=%0d overlap=%0d expected 1/0/0", ok_cnt, bad_cnt, n_both);
        end
    endtask

    task automatic test_check_vector();
        logic [7:0] vec [13];
        vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
        tx_bytes.delete();
        for (int i = 0; i < 13; i++) tx_bytes.push_back(vec[i]);
        model(1'b0);
        clear_mon();
        send_preamble(15);
        send_bytes(0, 13);
        idle(6);
        n_tests++;
        if (n_eof != 1 || eof_len !== 11'd13 || eof_crc !== 1'b1 || eof_err !== 4'b0010) begin
            n_fail++;
            $display("FAIL vector_status: got eofs=%0d len=%0d crc_ok=%0b err=%b expected 1/13/1/0010",
                     n_eof, eof_len, eof_crc, eof_err);
        end
        n_tests++;
        if (bad_cnt !== 16'd1 || ok_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL vector_counters: got ok=%0d bad=%0d expected 1/1", ok_cnt, bad_cnt);
        end
        n_tests++;
        if (rx_len !== 11'd13 || rx_err !== 4'b0010 || rx_crc_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL vector_hold: got len=%0d err=%b crc_ok=%0b expected 13/0010/1", rx_len, rx_err, rx_crc_ok);
        end
    endtask

    task automatic test_bit_flip();
        int unsigned pos;
        tx_bytes.delete();
        for (int i = 0; i < 60; i++) tx_bytes.push_back(8'($urandom));
        append_fcs();
        pos = $urandom_range(0, 59);
        tx_bytes[pos] = tx_bytes[pos] ^ (8'd1 << $urandom_range(0, 7));
        model(1'b0);
        clear_mon();
        send_preamble(15);
        send_bytes(0, tx_bytes.size());
        idle(4);
        n_tests++;
        if (n_eof != 1 || eof_len !== 11'd64 || eof_crc !== 1'b0 || eof_err !== 4'b0001) begin
            n_fail++;
            $display("FAIL flip_status: got eofs=%0d len=%0d crc_ok=%0b err=%b expected 1/64/0/0001",
                     n_eof, eof_len, eof_crc, eof_err);
        end
        n_tests++;
        if (bad_cnt !== 16'd2 || ok_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL flip_counters: got ok=%0d bad=%0d expected 1/2", ok_cnt, bad_cnt);
        end
    endtask

    task automatic test_too_long();
        int bad_i;
        tx_bytes.delete();
        for (int i = 0; i < 1600; i++) tx_bytes.push_back(8'($urandom));
        model(1'b0);
        clear_mon();
        send_preamble(15);
        send_bytes(0, 1600);
        idle(4);
        n_tests++;
        if (got_bytes.size() !== 1518) begin
            n_fail++;
            $display("FAIL long_valid_count: got %0d expected 1518", got_bytes.size());
        end
        bad_i = -1;
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            if (bad_i < 0 && got_bytes[i] !== exp_bytes[i]) bad_i = i;
        n_tests++;
        if (bad_i >= 0) begin
            n_fail++;
            $display("FAIL long_data: byte %0d got %0h expected %0h", bad_i, got_bytes[bad_i], exp_bytes[bad_i]);
        end
        n_tests++;
        if (n_eof != 1 || eof_len !== 11'd1519 || eof_err[3:1] !== 3'b010) begin
            n_fail++;
            $display("FAIL long_status: got eofs=%0d len=%0d err=%b expected 1/1519/010x", n_eof, eof_len, eof_err);
        end
        n_tests++;
        if (bad_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL long_counter: got bad=%0d expected 3", bad_cnt);
        end
    endtask

    task automatic test_odd_nibble();
        tx_bytes.delete();
        for (int i = 0; i < 60; i++) tx_bytes.push_back(8'($urandom));
        append_fcs();
        model(1'b1);
        clear_mon();
        send_preamble(15);
        send_bytes(0, tx_bytes.size());
        nib_cyc(1'b1, 4'($urandom));
        idle(4);
        n_tests++;
        if (n_eof != 1 || eof_len !== 11'd64 || eof_crc !== 1'b1 || eof_err !== 4'b1000 || got_bytes.size() != 64) begin
            n_fail++;
            $display("FAIL odd_status: got eofs=%0d len=%0d crc_ok=%0b err=%b bytes=%0d expected 1/64/1/1000/64",
                     n_eof, eof_len, eof_crc, eof_err, got_bytes.size());
        end
        n_tests++;
        if (bad_cnt !== 16'd4 || ok_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL odd_counters: got ok=%0d bad=%0d expected 1/4", ok_cnt, bad_cnt);
        end
        clear_mon();
        nib_cyc(1'b1, 4'h7);
        send_preamble(14);
        send_bytes(0, 20);
        idle(4);
        n_tests++;
        if (n_eof != 0 || got_bytes.size() != 0 || bad_cnt !== 16'd4 || ok_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL drop_bad_preamble: got eofs=%0d bytes=%0d ok=%0d bad=%0d expected 0/0/1/4",
                     n_eof, got_bytes.size(), ok_cnt, bad_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int         bad_i;
        tx_bytes.delete();
        for (int i = 0; i < 70; i++) tx_bytes.push_back(8'($urandom));
        append_fcs();
        clear_mon();
        send_preamble(15);
        send_bytes(0, 10);
        b = tx_bytes[10];
        @(negedge clk);
        rst_n = 1'b0;
        dv    = 1'b1;
        nib   = b[3:0];
        @(negedge clk);
        n_tests++;
        if ({rx_data, rx_valid, rx_sof, rx_eof, rx_len, rx_crc_ok, rx_err, ok_cnt, bad_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got data=%0h v=%0b e=%0b len=%0d err=%b ok=%0d bad=%0d expected all 0",
                     rx_data, rx_valid, rx_eof, rx_len, rx_err, ok_cnt, bad_cnt);
        end
        rst_n = 1'b1;
        nib   = b[7:4];
        clear_mon();
        exp_ok  = 0;
        exp_bad = 0;
        send_bytes(11, tx_bytes.size());
        idle(4);
        n_tests++;
        if (n_eof != 0 || got_bytes.size() != 0 || ok_cnt !== 16'd0 || bad_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got eofs=%0d bytes=%0d ok=%0d bad=%0d expected 0/0/0/0",
                     n_eof, got_bytes.size(), ok_cnt, bad_cnt);
        end
        tx_bytes.delete();
        for (int i = 0; i < 80; i++) tx_bytes.push_back(8'($urandom));
        append_fcs();
        model(1'b0);
        clear_mon();
        send_preamble(15);
        send_bytes(0, tx_bytes.size());
        idle(4);
        bad_i = (got_bytes.size() == exp_bytes.size()) ? -1 : 0;
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            if (bad_i < 0 && got_bytes[i] !== exp_bytes[i]) bad_i = i;
        n_tests++;
        if (bad_i >= 0 || n_eof != 1 || eof_len !== 11'd84 || eof_err !== 4'b0000 || ok_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL midreset_next_frame: got bytes=%0d eofs=%0d len=%0d err=%b ok=%0d expected 84/1/84/0000/1",
                     got_bytes.size(), n_eof, eof_len, eof_err, ok_cnt);
        end
    endtask

    task automatic test_random_frames();
        int          plen;
        int          bad_i;
        logic        odd;
        int unsigned pos;
        for (int f = 0; f < 10; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 6)) nib_cyc(1'b1, 4'h5);
                idle(2);
            end
            plen = $urandom_range(10, 120);
            tx_bytes.delete();
            for (int i = 0; i < plen; i++) tx_bytes.push_back(8'($urandom));
            append_fcs();
            if ($urandom_range(0, 3) == 0) begin
                pos = $urandom_range(0, tx_bytes.size() - 1);
                tx_bytes[pos] = tx_bytes[pos] ^ (8'd1 << $urandom_range(0, 7));
            end
            odd = ($urandom_range(0, 3) == 0);
            model(odd);
            clear_mon();
            send_preamble($urandom_range(1, 15));
            send_bytes(0, tx_bytes.size());
            if (odd) nib_cyc(1'b1, 4'($urandom));
            idle($urandom_range(3, 6));
            bad_i = (got_bytes.size() == exp_bytes.size()) ? -1 : 0;
            for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
                if (bad_i < 0 && got_bytes[i] !== exp_bytes[i]) bad_i = i;
            n_tests++;
            if (bad_i >= 0 || sof_idx.size() != 1 || sof_idx[0] != 0 || n_sof_stray != 0) begin
                n_fail++;
                $display("FAIL rand_data f%0d: got bytes=%0d first diff=%0d sofs=%0d expected bytes=%0d",
                         f, got_bytes.size(), bad_i, sof_idx.size(), exp_bytes.size());
            end
            n_tests++;
            if (n_eof != 1 || eof_len !== 11'(exp_len) || eof_crc !== exp_crc_ok || eof_err !== exp_err) begin
                n_fail++;
                $display("FAIL rand_status f%0d: got eofs=%0d len=%0d crc_ok=%0b err=%b expected 1/%0d/%0b/%b",
                         f, n_eof, eof_len, eof_crc, eof_err, exp_len, exp_crc_ok, exp_err);
            end
            n_tests++;
            if (ok_cnt !== 16'(exp_ok) || bad_cnt !== 16'(exp_bad) || n_both != 0) begin
                n_fail++;
                $display("FAIL rand_counters f%0d: got ok=%0d bad=%0d overlap=%0d expected %0d/%0d/0",
                         f, ok_cnt, bad_cnt, n_both, exp_ok, exp_bad);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dv    = 1'b0;
        nib   = 4'h0;
        clear_mon();
        test_reset();
        test_good_frame();
        test_check_vector();
        test_bit_flip();
        test_too_long();
        test_odd_nibble();
        test_reset_mid_frame();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
